// File: rtl/axi_rb_rd_slave.sv
// AXI4 read-channel slave serving INCR bursts from a word-addressed RAM with a side preload port.
// Optional AXI_RD_BOUNDS_CHK_EN: out-of-range words return zero data with SLVERR instead of aliasing.
module axi_rb_rd_slave #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic [1:0]               s_axi_arburst,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BEAT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                busy_q, busy_d;
  logic [31:0]         rdata_q;
  logic [IDX_W-1:0]    idx_c;
  logic                oob_c;
  logic [31:0]         mem [DEPTH];

  // Burst type, beat size and the byte offset carry no information for this slave
  logic unused_ok;
  assign unused_ok = ^{s_axi_arburst, s_axi_arsize, s_axi_araddr[1:0]};

  assign idx_c = word_q[IDX_W-1:0];

`ifdef AXI_RD_BOUNDS_CHK_EN
  assign oob_c = 32'(word_q) >= DEPTH;
`else
  assign oob_c = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rlast_d = rlast_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          word_d  = s_axi_araddr[ADDR_W-1:2];
          cnt_d   = s_axi_arlen;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rlast_d = (cnt_q == 8'd0);
        rresp_d = oob_c ? RESP_SLVERR : RESP_OKAY;
        state_d = BEAT;
      end
      BEAT: begin
        if (s_axi_rready) begin
          rlast_d = 1'b0;
          rresp_d = RESP_OKAY;
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            word_d  = word_q + WORD_W'(1);
            cnt_d   = cnt_q - 8'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
    rvalid_d  = (state_d == BEAT);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      busy_q    <= busy_d;
    end
  end

  // Read port: captured only in FETCH so a held beat ignores later preloads
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == FETCH) begin
      rdata_q <= oob_c ? 32'h0 : mem[idx_c];
    end
  end

  // Preload port; a same-cycle read of the same word sees the old contents
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axi_rb_rd_slave.sv
// Scoreboard bench for axi_rb_rd_slave (DEPTH=256, ADDR_W=16); expectations follow AXI_RD_BOUNDS_CHK_EN.
module tb_axi_rb_rd_slave;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 16;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [1:0]        s_axi_arburst;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic              ld_en;
  logic [7:0]        ld_addr;
  logic [31:0]       ld_data;
  logic              busy;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  beat_t       exp_q[$];
  logic [31:0] shadow [DEPTH];

  axi_rb_rd_slave #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted beat is popped and compared
  always @(negedge clk) begin
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      beat_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got d=%h r=%b l=%b", s_axi_rdata, s_axi_rresp, s_axi_rlast);
      end else begin
        e = exp_q.pop_front();
        if ({s_axi_rdata, s_axi_rresp, s_axi_rlast} !== {e.d, e.r, e.l}) begin
          bad++;
          $display("FAIL beat got d=%h r=%b l=%b want d=%h r=%b l=%b",
                   s_axi_rdata, s_axi_rresp, s_axi_rlast, e.d, e.r, e.l);
        end
      end
    end
  end

  function automatic beat_t model_beat(input int w, input logic last);
    beat_t b;
    b.l = last;
`ifdef AXI_RD_BOUNDS_CHK_EN
    if (w >= DEPTH) begin
      b.d = 32'h0;
      b.r = 2'b10;
    end else begin
      b.d = shadow[w];
      b.r = 2'b00;
    end
`else
    b.d = shadow[w % DEPTH];
    b.r = 2'b00;
`endif
    return b;
  endfunction

  task automatic preload(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = 8'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    shadow[a] = d;
  endtask

  // Pushes the burst's expected beats, then waits (bounded) for the AR handshake
  task automatic issue_ar(input logic [15:0] addr, input logic [7:0] len, output int c0);
    int w0;
    w0 = int'(addr >> 2);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(model_beat((w0 + i) % WORDS, i == int'(len)));
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    c0 = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin c0 = cyc; break; end
    end
    if (c0 < 0) begin
      total++; bad++;
      $display("FAIL ar_handshake got timeout want arready");
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && s_axi_arready) begin ok = 1; break; end
    end
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL drain got pending=%0d busy=%b want pending=0 busy=0", exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rdata, busy} !== 38'h0) begin
      bad++;
      $display("FAIL reset_state got ar=%b rv=%b rl=%b rr=%b rd=%h busy=%b want all 0",
               s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rdata, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (s_axi_arready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got ar=%b busy=%b want ar=1 busy=0", s_axi_arready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int c0, rv_c, ar_c;
    rv_c = -1; ar_c = -1;
    s_axi_rready = 1'b1;
    issue_ar(16'h0010, 8'd3, c0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin rv_c = cyc; break; end
    end
    total++;
    if (rv_c != c0 + 2) begin
      bad++;
      $display("FAIL first_rvalid got cycle %0d want %0d", rv_c - c0, 2);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin ar_c = cyc; break; end
    end
    // last beat accepted 8 edges after the handshake edge; arready visible the cycle after
    total++;
    if (ar_c != c0 + 9) begin
      bad++;
      $display("FAIL arready_return got cycle %0d want %0d", ar_c - c0, 9);
    end
    wait_idle(20);
  endtask

  task automatic test_stall();
    int c0, seen;
    seen = 0;
    s_axi_rready = 1'b1;
    issue_ar(16'h0010, 8'd3, c0);
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (s_axi_rvalid && s_axi_rready) seen = 1;
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) seen = 1;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1005 || s_axi_rlast !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got rv=%b d=%h l=%b want rv=1 d=00001005 l=0",
                 k, s_axi_rvalid, s_axi_rdata, s_axi_rlast);
      end
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b1;
    wait_idle(30);
  endtask

  task automatic test_single_and_bounds();
    int c0;
    s_axi_rready = 1'b1;
    issue_ar(16'h0003, 8'd0, c0);
    wait_idle(20);
    issue_ar(16'h03FC, 8'd1, c0);
    wait_idle(20);
    issue_ar(16'hFFFC, 8'd1, c0);
    wait_idle(20);
    issue_ar(16'h0300, 8'd255, c0);
    wait_idle(700);
  endtask

  task automatic test_back_to_back();
    int c0;
    s_axi_rready = 1'b1;
    issue_ar(16'h0040, 8'd1, c0);
    @(negedge clk);
    total++;
    if (s_axi_arready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_block got ar=%b busy=%b want ar=0 busy=1", s_axi_arready, busy);
    end
    @(posedge clk); #1;
    issue_ar(16'h0080, 8'd2, c0);
    wait_idle(30);
  endtask

  task automatic test_mid_reset();
    int c0, seen;
    seen = 0;
    s_axi_rready = 1'b1;
    issue_ar(16'h0000, 8'd3, c0);
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (s_axi_rvalid && s_axi_rready) seen = 1;
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) seen = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (s_axi_rvalid !== 1'b0 || busy !== 1'b0 || s_axi_rlast !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got rv=%b busy=%b rl=%b want 0 0 0", s_axi_rvalid, busy, s_axi_rlast);
    end
    rst = 1'b0;
    exp_q.delete();
    s_axi_rready = 1'b1;
    issue_ar(16'h0020, 8'd1, c0);
    wait_idle(30);
  endtask

  task automatic test_collision();
    int c0;
    s_axi_rready = 1'b1;
    issue_ar(16'h0014, 8'd0, c0);
    // this cycle is FETCH of word 5
    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 32'h0000DEAD;
    @(posedge clk); #1;
    ld_en = 1'b0;
    shadow[5] = 32'h0000DEAD;
    wait_idle(20);
    issue_ar(16'h0014, 8'd0, c0);
    wait_idle(20);
  endtask

  task automatic test_random_rready();
    int c0;
    issue_ar(16'h0008, 8'd9, c0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      s_axi_rready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !busy) break;
    end
    s_axi_rready = 1'b1;
    wait_idle(60);
  endtask

  initial begin
    rst = 1'b1;
    s_axi_araddr = '0; s_axi_arburst = 2'b01; s_axi_arlen = '0; s_axi_arsize = 3'd2;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) preload(i, 32'h1000 + i);
    test_basic();
    test_stall();
    test_single_and_bounds();
    test_back_to_back();
    test_mid_reset();
    test_collision();
    test_random_rready();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rb_rd_slave.md
# axi_rb_rd_slave

AXI4 read-channel slave backed by a word-addressed on-chip RAM. It serves INCR bursts to the `axi_rb` burst-read master and feeds it data beats: it accepts the AR request, then returns `arlen+1` 32-bit beats on R with valid/ready flow control. The RAM is preloaded through a simple side write port, which test benches and the host loader use. It sits directly upstream of `axi_rb` on its `s_axi_*` read channel.

## Interface
- `DEPTH`, 256: RAM words; power of two, 2..16384.
- `ADDR_W`, 16: AXI byte-address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_axi_araddr` in ADDR_W: burst start byte address.
- `s_axi_arburst` in 2: ignored; always treated as INCR.
- `s_axi_arlen` in 8: beats minus one.
- `s_axi_arsize` in 3: ignored; beats are always 4 bytes.
- `s_axi_arvalid` in 1: AR request valid.
- `s_axi_arready` out 1: AR accept.
- `s_axi_rdata` out 32: beat data.
- `s_axi_rresp` out 2: 2'b00 OKAY, 2'b10 SLVERR (macro only).
- `s_axi_rlast` out 1: final beat of the burst.
- `s_axi_rvalid` out 1: beat valid.
- `s_axi_rready` in 1: beat accept.
- `ld_en` in 1: preload write enable.
- `ld_addr` in $clog2(DEPTH): preload word index.
- `ld_data` in 32: preload data.
- `busy` out 1: burst in progress (state is not IDLE).

## Operation
- RAM: `DEPTH` x 32, synchronous read, one preload write port. Reset does not clear contents.
- State machine:
  - **IDLE**: `arready`=1. When `arvalid && arready`, latch `word = araddr[ADDR_W-1:2]` and `cnt = arlen`, then go to FETCH. `araddr[1:0]` is ignored.
  - **FETCH**: issue the RAM read of `word`, then go to BEAT.
  - **BEAT**: `rvalid`=1. `rdata`, `rresp`, and `rlast` (which is `cnt==0`) stay stable until `rready` is sampled high.
    - On `rready` with `cnt==0`: go to IDLE.
    - On `rready` otherwise: `word <= word+1` (wraps mod 2^(ADDR_W-2)), `cnt <= cnt-1`, then go to FETCH.
- `arready` is 0 outside IDLE. A request arriving while busy waits because the slave does not accept it.
- Preload with `ld_en` is allowed in any state.
  - If a preload write and the FETCH read target the same word in the same cycle, the read returns the old data.
  - A word already held in BEAT is unaffected by later writes to that word.
- Out-of-range indices (`word >= DEPTH`): handling is set by the macro below.

## Timing
- Reset values: `arready`=0 during reset, then 1 on the first cycle in IDLE. `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0, `busy`=0. State goes to IDLE, and `word` and `cnt` are cleared.
- AR handshake in cycle t gives first `rvalid` in cycle t+2.
- Each accepted beat is followed by a 1-cycle FETCH bubble. The next beat has `rvalid` two cycles after the accepting `rready` edge.
- A burst of N beats with `rready` held at 1 takes 2N cycles from the AR handshake to the return to IDLE. `arready` is re-asserted in the cycle after the last beat is accepted.
- `rvalid` never drops without a handshake.
- Reset in the middle of a burst abandons the burst: `rvalid`=0 from the next edge, and no partial-burst state is retained.
- `arlen`=255 gives 256 beats. `cnt` is 8 bits and never underflows.

## Configuration
- `AXI_RD_BOUNDS_CHK_EN` defined:
  - A beat whose index is `>= DEPTH` returns `rdata`=0 and `rresp`=2'b10.
  - The burst continues, and `rlast` is unchanged.
- Not defined:
  - The index is taken as `word[$clog2(DEPTH)-1:0]`, which aliases around the RAM.
  - `rresp` is tied to 2'b00.

## Test plan
- Preload `mem[i]=0x1000+i`, i=0..15. Request AR `araddr`=0x0010, `arlen`=3 with `rready`=1 -> beats 0x1004..0x1007, `rlast` only on the 4th beat, first `rvalid` at t+2, `arready` back 8 cycles after the handshake.
- Same burst with `rready` low for 5 cycles on beat 2 -> `rvalid`/`rdata`=0x1005 held stable for those cycles, and no beat is lost or duplicated.
- `arlen`=0 with `araddr`=0x0003 -> a single beat `mem[0]`, `rlast`=1.
- DEPTH=256, `araddr`=0x03FC, `arlen`=1:
  - With the macro: beat0=`mem[255]` OKAY, beat1=0 SLVERR.
  - Without the macro: beat1=`mem[0]`.
- Assert `rst` during beat 2 of a 4-beat burst -> `rvalid`=0 next cycle. A new AR afterwards returns correct data from its own start.
- `ld_en` writes 0xDEAD to `word` 5 in the cycle when FETCH reads word 5 -> the beat returns the old value, and a subsequent burst returns 0xDEAD.
